// File: rtl/seg7_pkg.sv
// Shared constants, digit-index type and active-low segment table for the
// eight-digit seven-segment scan driver.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned IDX_W      = 3;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef logic [IDX_W-1:0] digit_idx_t;

   // {g,f,e,d,c,b,a}, active-low, indexed by hex nibble
   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [SEG_W-1:0] seg_lookup(input logic [NIB_W-1:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data/strobe inputs and display outputs of the scan driver.
// master = upstream datapath side, slave = the driver itself.
interface seg7_scan_driver_if;
   import seg7_pkg::*;

   logic [DATA_W-1:0]     data_in;
   logic [NUM_DIGITS-1:0] dp_in;
   logic [NUM_DIGITS-1:0] digit_en;
   logic                  load;
   logic [SEG_W-1:0]      Cnode;
   logic                  dp;
   logic [NUM_DIGITS-1:0] AN;
   logic                  frame_done;

   modport master (
      output data_in, dp_in, digit_en, load,
      input  Cnode, dp, AN, frame_done
   );

   modport slave (
      input  data_in, dp_in, digit_en, load,
      output Cnode, dp, AN, frame_done
   );

endinterface

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low {g..a} segment decoder.
module hex7seg_dec
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] i_nibble,
   output logic [SEG_W-1:0] o_seg_c
);

   assign o_seg_c = seg_lookup(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed common-anode seven-segment scan driver with a
// double-buffered display value. Optional feature: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
)(
   input  logic                clkt,
   input  logic                rst,
   seg7_scan_driver_if.slave   io_bus
);

   localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);

   logic [PRESC_W-1:0]    r_presc;
   digit_idx_t            r_idx;
   logic                  r_run;
   logic [DATA_W-1:0]     r_shown;
   logic [DATA_W-1:0]     r_pending;
   logic                  r_pend;
   logic [NUM_DIGITS-1:0] r_an;
   logic [SEG_W-1:0]      r_seg;
   logic                  r_dp;
   logic                  r_frame_done;

   logic                  w_tick;
   logic                  w_wrap;
   logic [NIB_W-1:0]      w_nibble;
   logic [SEG_W-1:0]      w_seg;
   logic                  w_lit;
   logic                  w_lz_blank;
   logic [NUM_DIGITS-1:0] w_an_lit;

   assign w_tick   = (r_presc == PRESC_W'(REFRESH_DIV - 1));
   assign w_wrap   = w_tick && (r_idx == digit_idx_t'(NUM_DIGITS - 1));
   assign w_nibble = r_shown[{r_idx, 2'b00} +: NIB_W];
   assign w_lit    = r_run && io_bus.digit_en[r_idx];
   assign w_an_lit = ~(NUM_DIGITS'(1) << r_idx);

   hex7seg_dec u_dec (
      .i_nibble (w_nibble),
      .o_seg_c  (w_seg)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   digit_idx_t w_msnz;

   // Highest nonzero nibble; an all-zero value reports 0 so digit 0 stays lit
   always_comb begin
      w_msnz = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (r_shown[k*NIB_W +: NIB_W] != '0) w_msnz = digit_idx_t'(k);
      end
   end

   assign w_lz_blank = (r_idx > w_msnz);
`else
   assign w_lz_blank = 1'b0;
`endif

   // Prescaler, digit index and first-tick run flag
   always_ff @(posedge clkt or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= digit_idx_t'(NUM_DIGITS - 1);
         r_run   <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
         if (w_tick) begin
            r_idx <= r_idx + digit_idx_t'(1);
            r_run <= 1'b1;
         end
      end
   end

   // Pending/shown double buffer; shown only changes at a frame boundary
   always_ff @(posedge clkt or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_pend    <= 1'b0;
         r_shown   <= '0;
      end else begin
         if (io_bus.load) r_pending <= io_bus.data_in;
         if (w_wrap) begin
            r_pend <= 1'b0;
            if (io_bus.load)  r_shown <= io_bus.data_in;
            else if (r_pend)  r_shown <= r_pending;
         end else if (io_bus.load) begin
            r_pend <= 1'b1;
         end
      end
   end

   // Registered display outputs; blank until the first tick has happened
   always_ff @(posedge clkt or posedge rst) begin
      if (rst) begin
         r_an         <= '1;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         if (w_lit) begin
            r_an  <= w_an_lit;
            r_seg <= w_lz_blank ? SEG_BLANK : w_seg;
            r_dp  <= ~io_bus.dp_in[r_idx];
         end else begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
         end
      end
   end

   assign io_bus.AN         = r_an;
   assign io_bus.Cnode      = r_seg;
   assign io_bus.dp         = r_dp;
   assign io_bus.frame_done = r_frame_done;

endmodule
